// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment bit order and the hex pattern table (active-low, g..a).
// Used by both the encoder and the scan-reader sides of the display interface.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam logic [6:0] SEG7_HEX_0 = 7'h40;
    localparam logic [6:0] SEG7_HEX_1 = 7'h79;
    localparam logic [6:0] SEG7_HEX_2 = 7'h24;
    localparam logic [6:0] SEG7_HEX_3 = 7'h30;
    localparam logic [6:0] SEG7_HEX_4 = 7'h19;
    localparam logic [6:0] SEG7_HEX_5 = 7'h12;
    localparam logic [6:0] SEG7_HEX_6 = 7'h02;
    localparam logic [6:0] SEG7_HEX_7 = 7'h78;
    localparam logic [6:0] SEG7_HEX_8 = 7'h00;
    localparam logic [6:0] SEG7_HEX_9 = 7'h10;
    localparam logic [6:0] SEG7_HEX_A = 7'h08;
    localparam logic [6:0] SEG7_HEX_B = 7'h03;
    localparam logic [6:0] SEG7_HEX_C = 7'h46;
    localparam logic [6:0] SEG7_HEX_D = 7'h21;
    localparam logic [6:0] SEG7_HEX_E = 7'h06;
    localparam logic [6:0] SEG7_HEX_F = 7'h0E;

    localparam logic [6:0] SEG7_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Reverse hex lookup: active-low g..a pattern -> {hit, nibble}; purely combinational, no backpressure.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       hit_o,
    output logic [3:0] nibble_o
);

    always_comb begin
        hit_o    = 1'b1;
        nibble_o = 4'h0;
        case (pat_i)
            SEG7_HEX_0: nibble_o = 4'h0;
            SEG7_HEX_1: nibble_o = 4'h1;
            SEG7_HEX_2: nibble_o = 4'h2;
            SEG7_HEX_3: nibble_o = 4'h3;
            SEG7_HEX_4: nibble_o = 4'h4;
            SEG7_HEX_5: nibble_o = 4'h5;
            SEG7_HEX_6: nibble_o = 4'h6;
            SEG7_HEX_7: nibble_o = 4'h7;
            SEG7_HEX_8: nibble_o = 4'h8;
            SEG7_HEX_9: nibble_o = 4'h9;
            SEG7_HEX_A: nibble_o = 4'hA;
            SEG7_HEX_B: nibble_o = 4'hB;
            SEG7_HEX_C: nibble_o = 4'hC;
            SEG7_HEX_D: nibble_o = 4'hD;
            SEG7_HEX_E: nibble_o = 4'hE;
            SEG7_HEX_F: nibble_o = 4'hF;
            default:    hit_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Scanned 7-seg bus reader: debounces (strobe, pattern), decodes and holds per-digit results.
// Latency: results land on the STABLE_CYC-th identical sampling edge; passive monitor, no backpressure.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int NDIG       = 4,
    parameter int STABLE_CYC = 3,
    parameter int CW         = 8,
    localparam int IW        = (NDIG > 1) ? $clog2(NDIG) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        seg,
    input  logic [NDIG-1:0]   dig_sel,
    output logic [4*NDIG-1:0] value,
    output logic [NDIG-1:0]   digit_valid,
    output logic [NDIG-1:0]   err,
    output logic [NDIG-1:0]   dp,
    output logic              upd,
    output logic [IW-1:0]     upd_idx
);

    localparam logic [CW-1:0] RUN_MAX = CW'(STABLE_CYC);

    logic [CW-1:0]     run_q, run_d;
    logic [NDIG-1:0]   prev_sel_q;
    logic [7:0]        prev_seg_q;
    logic              prev_valid_q;
    logic              same, one_hot, commit, hit;
    logic [3:0]        nib;
    logic [IW-1:0]     idx;
    logic [4*NDIG-1:0] value_q, value_d;
    logic [NDIG-1:0]   valid_q, valid_d, err_q, err_d, dp_q, dp_d;
    logic              upd_q, upd_d;
    logic [IW-1:0]     upd_idx_q, upd_idx_d;

    seg7_pattern_lookup u_lookup (
        .pat_i    (seg[6:0]),
        .hit_o    (hit),
        .nibble_o (nib)
    );

    assign same    = prev_valid_q && (dig_sel == prev_sel_q) && (seg == prev_seg_q);
    assign one_hot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);

    always_comb begin
        run_d = CW'(1);
        if (same) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + CW'(1);
        end
    end

    // A saturated run keeps run_d == RUN_MAX, so exclude it to avoid recommitting.
    assign commit = one_hot && (run_d == RUN_MAX) && !(same && (run_q == RUN_MAX));

    always_comb begin
        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_sel[i]) idx = IW'(i);
        end
    end

    always_comb begin
        value_d   = value_q;
        valid_d   = valid_q;
        err_d     = err_q;
        dp_d      = dp_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;
        if (commit) begin
            upd_d     = 1'b1;
            upd_idx_d = idx;
            for (int i = 0; i < NDIG; i++) begin
                if (dig_sel[i]) begin
                    if (hit) begin
                        value_d[4*i +: 4] = nib;
                        valid_d[i]        = 1'b1;
                        err_d[i]          = 1'b0;
                    end else begin
                        valid_d[i]        = 1'b0;
                        err_d[i]          = 1'b1;
                    end
                    dp_d[i] = ~seg[SEG_DP];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_q        <= '0;
            prev_sel_q   <= '0;
            prev_seg_q   <= '0;
            prev_valid_q <= 1'b0;
            value_q      <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            dp_q         <= '0;
            upd_q        <= 1'b0;
            upd_idx_q    <= '0;
        end else begin
            run_q <= run_d;
            if (!same) begin
                prev_sel_q   <= dig_sel;
                prev_seg_q   <= seg;
                prev_valid_q <= 1'b1;
            end
            value_q   <= value_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            dp_q      <= dp_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign value       = value_q;
    assign digit_valid = valid_q;
    assign err         = err_q;
    assign dp          = dp_q;
    assign upd         = upd_q;
    assign upd_idx     = upd_idx_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for the scanned 7-seg reader; second instance runs with a one-sample debounce.
module tb_seg7_scan_decoder;

    logic        clk;
    logic        rst;
    logic [7:0]  seg;
    logic [3:0]  dig_sel;

    logic [15:0] value0, value1;
    logic [3:0]  dv0, dv1, err0, err1, dp0, dp1;
    logic        upd0, upd1;
    logic [1:0]  idx0, idx1;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [16];

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(3), .CW(8)) dut0 (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .value(value0), .digit_valid(dv0), .err(err0), .dp(dp0),
        .upd(upd0), .upd_idx(idx0)
    );

    seg7_scan_decoder #(.NDIG(4), .STABLE_CYC(1), .CW(8)) dut1 (
        .clk(clk), .rst(rst), .seg(seg), .dig_sel(dig_sel),
        .value(value1), .digit_valid(dv1), .err(err1), .dp(dp1),
        .upd(upd1), .upd_idx(idx1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        // Reset with random bus activity
        rst     = 1'b1;
        seg     = 8'($urandom);
        dig_sel = 4'($urandom);
        step();
        seg     = 8'($urandom);
        dig_sel = 4'($urandom);
        step();
        check("rst_value", 32'(value0), 32'h0);
        check("rst_valid", 32'(dv0), 32'h0);
        check("rst_err",   32'(err0), 32'h0);
        check("rst_dp",    32'(dp0), 32'h0);
        check("rst_upd",   32'(upd0), 32'h0);
        check("rst_idx",   32'(idx0), 32'h0);
        rst     = 1'b0;
        seg     = 8'hFF;
        dig_sel = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            step();
            check("idle_upd", 32'(upd0), 32'h0);
        end

        // Basic commit: "2", dp off, digit 0
        seg     = 8'hA4;
        dig_sel = 4'b0001;
        step();
        check("basic_e1_upd", 32'(upd0), 32'h0);
        step();
        check("basic_e2_upd", 32'(upd0), 32'h0);
        step();
        check("basic_upd",   32'(upd0), 32'h1);
        check("basic_idx",   32'(idx0), 32'h0);
        check("basic_value", 32'(value0[3:0]), 32'h2);
        check("basic_valid", 32'(dv0), 32'b0001);
        check("basic_dp",    32'(dp0), 32'h0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_no_upd", 32'(upd0), 32'h0);
        end

        // Glitch: "4" for 2 edges, then "5" (dp lit) for 3 edges on digit 1
        seg     = 8'h19;
        dig_sel = 4'b0010;
        step();
        check("glitch_e1_upd", 32'(upd0), 32'h0);
        step();
        check("glitch_e2_upd", 32'(upd0), 32'h0);
        seg = 8'h12;
        step();
        check("glitch_e3_upd", 32'(upd0), 32'h0);
        step();
        check("glitch_e4_upd", 32'(upd0), 32'h0);
        step();
        check("glitch_upd",   32'(upd0), 32'h1);
        check("glitch_idx",   32'(idx0), 32'h1);
        check("glitch_value", 32'(value0), 32'h0052);
        check("glitch_valid", 32'(dv0), 32'b0011);
        check("glitch_dp",    32'(dp0), 32'b0010);

        // Mid-run reset discards the partial run
        seg = 8'h99;
        step();
        step();
        check("midrst_pre_upd", 32'(upd0), 32'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_value", 32'(value0), 32'h0);
        check("midrst_valid", 32'(dv0), 32'h0);
        step();
        check("midrst_e1_upd", 32'(upd0), 32'h0);
        step();
        check("midrst_e2_upd", 32'(upd0), 32'h0);
        step();
        check("midrst_upd",   32'(upd0), 32'h1);
        check("midrst_value", 32'(value0), 32'h0040);
        check("midrst_valid", 32'(dv0), 32'b0010);
        check("midrst_dp",    32'(dp0), 32'h0);

        // Unknown pattern on digit 2 after preloading "7"
        seg     = 8'hF8;
        dig_sel = 4'b0100;
        repeat (3) step();
        check("pre7_upd",   32'(upd0), 32'h1);
        check("pre7_value", 32'(value0), 32'h0740);
        check("pre7_valid", 32'(dv0), 32'b0110);
        seg = 8'hFF;
        repeat (3) step();
        check("unk_upd",   32'(upd0), 32'h1);
        check("unk_idx",   32'(idx0), 32'h2);
        check("unk_err",   32'(err0), 32'b0100);
        check("unk_valid", 32'(dv0), 32'b0010);
        check("unk_value", 32'(value0), 32'h0740);
        check("unk_dp",    32'(dp0), 32'h0);

        // Multi-hot and zero-hot strobes never commit
        seg     = 8'hC0;
        dig_sel = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            step();
            check("multihot_upd", 32'(upd0), 32'h0);
        end
        dig_sel = 4'b0000;
        for (int i = 0; i < 10; i++) begin
            step();
            check("zerohot_upd", 32'(upd0), 32'h0);
        end
        check("strobe_value", 32'(value0), 32'h0740);
        check("strobe_valid", 32'(dv0), 32'b0010);
        check("strobe_err",   32'(err0), 32'b0100);
        check("strobe_dp",    32'(dp0), 32'h0);
        check("strobe_idx",   32'(idx0), 32'h2);

        // Round trip on digit 3, dp lit, debounce of 3
        dig_sel = 4'b1000;
        for (int k = 0; k < 16; k++) begin
            seg = {1'b0, codes[k]};
            step();
            step();
            check("rt3_pre_upd", 32'(upd0), 32'h0);
            step();
            check("rt3_upd",   32'(upd0), 32'h1);
            check("rt3_idx",   32'(idx0), 32'h3);
            check("rt3_value", 32'(value0[15:12]), 32'(k));
            check("rt3_dp",    32'(dp0[3]), 32'h1);
            check("rt3_err",   32'(err0[3]), 32'h0);
        end
        check("rt3_others", 32'(value0[11:0]), 32'h740);

        // Round trip with debounce of 1: commit on first edge of each code
        for (int k = 0; k < 16; k++) begin
            seg = {1'b0, codes[k]};
            step();
            check("rt1_upd",   32'(upd1), 32'h1);
            check("rt1_idx",   32'(idx1), 32'h3);
            check("rt1_value", 32'(value1[15:12]), 32'(k));
            check("rt1_dp",    32'(dp1[3]), 32'h1);
            check("rt1_err",   32'(err1[3]), 32'h0);
        end
        step();
        check("rt1_sat_no_upd", 32'(upd1), 32'h0);
        check("rt1_sat_idx",    32'(idx1), 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
